// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the CPU-side Avalon-MM bus arbiter.
package mips_bus_pkg;

  // Arbiter sequencing states: one access in flight at a time.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DATA_RD = 3'd2,
    DATA_WR = 3'd3,
    DONE    = 3'd4
  } arb_state_t;

  // Full-word lane mask used for instruction fetches on a 32-bit bus.
  localparam logic [3:0] BE_WORD = 4'hF;

  // Which requester wins the bus in an IDLE cycle.
  typedef logic [1:0] grant_t;
  localparam grant_t GNT_NONE    = 2'd0;
  localparam grant_t GNT_FETCH   = 2'd1;
  localparam grant_t GNT_DATA_RD = 2'd2;
  localparam grant_t GNT_DATA_WR = 2'd3;

endpackage

// File: rtl/bus_watchdog.sv
// Counts consecutive waitrequest cycles of one bus access and flags when
// the slave has stalled for TIMEOUT cycles. TIMEOUT=0 disables it.
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic busy,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // The count holds busy cycles already elapsed, so the final one is TIMEOUT-1.
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expired = (TIMEOUT != 0) && busy && (count_q == LAST);

  // Next count: restart outside accesses, advance on each stalled cycle.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (busy && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Shares the CPU's single Avalon-MM master between instruction fetch and
// data load/store. Sequences one access at a time through waitrequest,
// returns read data with a one-cycle valid strobe and stalls the core via
// pause while an access is pending.
module avalon_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_W-1:0]     fetch_addr,
  output logic [DATA_W-1:0]     fetch_rdata,
  output logic                  fetch_valid,
  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  input  logic [DATA_W/8-1:0]   data_byteenable,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  data_valid,
  output logic                  pause,
  output logic                  bus_error,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_waitrequest
);

  arb_state_t            state_q,          state_d;
  logic [ADDR_W-1:0]     avm_address_q,    avm_address_d;
  logic                  avm_read_q,       avm_read_d;
  logic                  avm_write_q,      avm_write_d;
  logic [DATA_W-1:0]     avm_writedata_q,  avm_writedata_d;
  logic [DATA_W/8-1:0]   avm_byteenable_q, avm_byteenable_d;
  logic [DATA_W-1:0]     fetch_rdata_q,    fetch_rdata_d;
  logic [DATA_W-1:0]     data_rdata_q,     data_rdata_d;
  logic                  fetch_valid_q,    fetch_valid_d;
  logic                  data_valid_q,     data_valid_d;
  logic                  bus_error_q,      bus_error_d;

  grant_t grant;
  logic   in_access;
  logic   wd_clear;
  logic   wd_busy;
  logic   wd_expired;

  // The bus is word addressed; data byte offsets are carried by byteenable.
  logic   unused_data_lsb;
  assign  unused_data_lsb = ^data_addr[1:0];

  assign in_access = (state_q == FETCH) || (state_q == DATA_RD) || (state_q == DATA_WR);
  assign wd_clear  = !in_access;
  assign wd_busy   = in_access && avm_waitrequest;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .busy    (wd_busy),
    .expired (wd_expired)
  );

  // Fixed priority: the data access belongs to the instruction already in
  // the pipeline, so it must go before the next fetch.
  always_comb begin
    grant = GNT_NONE;
    if (data_write) begin
      grant = GNT_DATA_WR;
    end else if (data_read) begin
      grant = GNT_DATA_RD;
    end else if (fetch_req) begin
      grant = GNT_FETCH;
    end
  end

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d          = state_q;
    avm_address_d    = avm_address_q;
    avm_read_d       = avm_read_q;
    avm_write_d      = avm_write_q;
    avm_writedata_d  = avm_writedata_q;
    avm_byteenable_d = avm_byteenable_q;
    fetch_rdata_d    = fetch_rdata_q;
    data_rdata_d     = data_rdata_q;
    fetch_valid_d    = 1'b0;
    data_valid_d     = 1'b0;
    bus_error_d      = bus_error_q;

    case (state_q)
      IDLE: begin
        case (grant)
          GNT_DATA_WR: begin
            state_d          = DATA_WR;
            avm_address_d    = {data_addr[ADDR_W-1:2], 2'b00};
            avm_write_d      = 1'b1;
            avm_writedata_d  = data_wdata;
            avm_byteenable_d = data_byteenable;
            // Read and write together is a control fault; the write wins.
            if (data_read) begin
              bus_error_d = 1'b1;
            end
          end
          GNT_DATA_RD: begin
            state_d          = DATA_RD;
            avm_address_d    = {data_addr[ADDR_W-1:2], 2'b00};
            avm_read_d       = 1'b1;
            avm_byteenable_d = data_byteenable;
          end
          GNT_FETCH: begin
            if (fetch_addr[1:0] != 2'b00) begin
              // A misaligned PC never reaches the bus; return a zero word.
              state_d       = DONE;
              fetch_rdata_d = '0;
              fetch_valid_d = 1'b1;
              bus_error_d   = 1'b1;
            end else begin
              state_d          = FETCH;
              avm_address_d    = fetch_addr;
              avm_read_d       = 1'b1;
              avm_byteenable_d = '1;
            end
          end
          default: ;
        endcase
      end

      FETCH, DATA_RD, DATA_WR: begin
        if (!avm_waitrequest || wd_expired) begin
          state_d     = DONE;
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
          if (avm_waitrequest) begin
            bus_error_d = 1'b1;
          end
          case (state_q)
            FETCH: begin
              fetch_rdata_d = avm_waitrequest ? '0 : avm_readdata;
              fetch_valid_d = 1'b1;
            end
            DATA_RD: begin
              data_rdata_d = avm_waitrequest ? '0 : avm_readdata;
              data_valid_d = 1'b1;
            end
            default: begin
              data_valid_d = 1'b1;
            end
          endcase
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= IDLE;
      avm_address_q    <= '0;
      avm_read_q       <= 1'b0;
      avm_write_q      <= 1'b0;
      avm_writedata_q  <= '0;
      avm_byteenable_q <= '0;
      fetch_rdata_q    <= '0;
      data_rdata_q     <= '0;
      fetch_valid_q    <= 1'b0;
      data_valid_q     <= 1'b0;
      bus_error_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      avm_address_q    <= avm_address_d;
      avm_read_q       <= avm_read_d;
      avm_write_q      <= avm_write_d;
      avm_writedata_q  <= avm_writedata_d;
      avm_byteenable_q <= avm_byteenable_d;
      fetch_rdata_q    <= fetch_rdata_d;
      data_rdata_q     <= data_rdata_d;
      fetch_valid_q    <= fetch_valid_d;
      data_valid_q     <= data_valid_d;
      bus_error_q      <= bus_error_d;
    end
  end

  // Stall while a request waits for the bus or an access is in flight; the
  // DONE cycle releases the core so it consumes the valid data.
  assign pause = ((state_q == IDLE) && (data_read || data_write || fetch_req)) ||
                 ((state_q != IDLE) && (state_q != DONE));

  assign avm_address    = avm_address_q;
  assign avm_read       = avm_read_q;
  assign avm_write      = avm_write_q;
  assign avm_writedata  = avm_writedata_q;
  assign avm_byteenable = avm_byteenable_q;
  assign fetch_rdata    = fetch_rdata_q;
  assign data_rdata     = data_rdata_q;
  assign fetch_valid    = fetch_valid_q;
  assign data_valid     = data_valid_q;
  assign bus_error      = bus_error_q;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed bench for avalon_bus_arbiter with hand-computed expectations.
module tb_avalon_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_rdata;
  logic        fetch_valid;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_byteenable;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        pause;
  logic        bus_error;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  avalon_bus_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_req       (fetch_req),
    .fetch_addr      (fetch_addr),
    .fetch_rdata     (fetch_rdata),
    .fetch_valid     (fetch_valid),
    .data_read       (data_read),
    .data_write      (data_write),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_byteenable (data_byteenable),
    .data_rdata      (data_rdata),
    .data_valid      (data_valid),
    .pause           (pause),
    .bus_error       (bus_error),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    data_read = 1'b0; data_write = 1'b0; data_addr = '0;
    data_wdata = '0; data_byteenable = '0;
    avm_readdata = '0; avm_waitrequest = 1'b0;

    // Reset state
    cyc(); cyc();
    chk("rst_read", avm_read, 0);
    chk("rst_write", avm_write, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_pause", pause, 0);
    chk("rst_err", bus_error, 0);
    chk("rst_fvalid", fetch_valid, 0);
    reset = 1'b1;
    cyc();

    // Plain fetch, zero wait
    fetch_req = 1'b1; fetch_addr = 32'h0000_1000; avm_readdata = 32'h1234_5678; #1;
    chk("f_c0_pause", pause, 1);
    chk("f_c0_read", avm_read, 0);
    cyc();
    chk("f_c1_read", avm_read, 1);
    chk("f_c1_addr", avm_address, 32'h1000);
    chk("f_c1_be", avm_byteenable, 4'hF);
    chk("f_c1_pause", pause, 1);
    chk("f_c1_valid", fetch_valid, 0);
    cyc();
    chk("f_c2_valid", fetch_valid, 1);
    chk("f_c2_rdata", fetch_rdata, 32'h1234_5678);
    chk("f_c2_read", avm_read, 0);
    fetch_req = 1'b0; #1;
    chk("f_c2_pause", pause, 0);
    cyc();
    chk("f_c3_valid", fetch_valid, 0);

    // Data read beats fetch; fetch follows
    fetch_req = 1'b1; fetch_addr = 32'h0000_1004;
    data_read = 1'b1; data_addr = 32'h0000_2006; data_byteenable = 4'b0011;
    avm_readdata = 32'hCAFE_0001; #1;
    chk("a_c0_pause", pause, 1);
    cyc();
    chk("a_c1_read", avm_read, 1);
    chk("a_c1_addr", avm_address, 32'h2004);
    chk("a_c1_be", avm_byteenable, 4'b0011);
    cyc();
    chk("a_c2_dvalid", data_valid, 1);
    chk("a_c2_fvalid", fetch_valid, 0);
    chk("a_c2_drdata", data_rdata, 32'hCAFE_0001);
    data_read = 1'b0; avm_readdata = 32'h0BAD_F00D;
    cyc();
    chk("a_c3_read", avm_read, 0);
    chk("a_c3_pause", pause, 1);
    cyc();
    chk("a_c4_read", avm_read, 1);
    chk("a_c4_addr", avm_address, 32'h1004);
    chk("a_c4_be", avm_byteenable, 4'hF);
    cyc();
    chk("a_c5_fvalid", fetch_valid, 1);
    chk("a_c5_frdata", fetch_rdata, 32'h0BAD_F00D);
    chk("a_c5_drdata", data_rdata, 32'hCAFE_0001);
    fetch_req = 1'b0;
    cyc();

    // Write held through three waitrequest cycles
    data_write = 1'b1; data_addr = 32'h0000_300A; data_wdata = 32'hDEAD_BEEF;
    data_byteenable = 4'b1100; avm_waitrequest = 1'b1;
    cyc();
    data_wdata = 32'h0; data_byteenable = 4'b0000;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) avm_waitrequest = 1'b0;
      chk("w_write", avm_write, 1);
      chk("w_addr", avm_address, 32'h3008);
      chk("w_wdata", avm_writedata, 32'hDEAD_BEEF);
      chk("w_be", avm_byteenable, 4'b1100);
      chk("w_dvalid_low", data_valid, 0);
      cyc();
    end
    chk("w_dvalid", data_valid, 1);
    chk("w_write_off", avm_write, 0);
    chk("w_err", bus_error, 0);
    data_write = 1'b0; #1;
    chk("w_pause", pause, 0);
    cyc();
    chk("w_dvalid_once", data_valid, 0);

    // Watchdog abort after 8 stalled cycles
    fetch_req = 1'b1; fetch_addr = 32'h0000_1008;
    avm_readdata = 32'hFFFF_FFFF; avm_waitrequest = 1'b1;
    cyc();
    for (int i = 1; i <= 8; i++) begin
      chk("t_read_held", avm_read, 1);
      chk("t_fvalid_low", fetch_valid, 0);
      cyc();
    end
    chk("t_read_drop", avm_read, 0);
    chk("t_err", bus_error, 1);
    chk("t_fvalid", fetch_valid, 1);
    chk("t_frdata", fetch_rdata, 32'h0);
    fetch_req = 1'b0; avm_waitrequest = 1'b0; #1;
    chk("t_pause", pause, 0);
    cyc();

    // Reset during a stalled data read
    data_read = 1'b1; data_addr = 32'h0000_4000; data_byteenable = 4'hF;
    avm_waitrequest = 1'b1; avm_readdata = 32'h7777_7777;
    cyc();
    chk("r_read", avm_read, 1);
    reset = 1'b0; data_read = 1'b0;
    cyc();
    chk("r_read_off", avm_read, 0);
    chk("r_addr", avm_address, 0);
    chk("r_dvalid", data_valid, 0);
    chk("r_err", bus_error, 0);
    chk("r_pause", pause, 0);
    chk("r_frdata", fetch_rdata, 0);
    chk("r_drdata", data_rdata, 0);
    reset = 1'b1; avm_waitrequest = 1'b0;
    cyc();
    chk("r_dvalid_after", data_valid, 0);
    fetch_req = 1'b1; fetch_addr = 32'h0000_1010; avm_readdata = 32'h5555_AAAA;
    cyc();
    chk("r_f_read", avm_read, 1);
    chk("r_f_addr", avm_address, 32'h1010);
    cyc();
    chk("r_f_valid", fetch_valid, 1);
    chk("r_f_rdata", fetch_rdata, 32'h5555_AAAA);
    fetch_req = 1'b0;
    cyc();

    // Read/write conflict, then misaligned fetch
    data_read = 1'b1; data_write = 1'b1; data_addr = 32'h0000_5000;
    data_wdata = 32'h1111_2222; data_byteenable = 4'hF;
    cyc();
    chk("c_write", avm_write, 1);
    chk("c_read", avm_read, 0);
    chk("c_err", bus_error, 1);
    chk("c_wdata", avm_writedata, 32'h1111_2222);
    cyc();
    chk("c_dvalid", data_valid, 1);
    data_read = 1'b0; data_write = 1'b0;
    cyc();
    fetch_req = 1'b1; fetch_addr = 32'h0000_1002; #1;
    chk("m_c0_pause", pause, 1);
    cyc();
    chk("m_read", avm_read, 0);
    chk("m_fvalid", fetch_valid, 1);
    chk("m_frdata", fetch_rdata, 0);
    chk("m_err", bus_error, 1);
    fetch_req = 1'b0;
    cyc();
    chk("m_fvalid_once", fetch_valid, 0);
    chk("m_err_sticky", bus_error, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
